fifo_write_arbiter: RTL

- Round-robin arbiter that shares the single write port of the asynchronous FIFO (wrena/wrdata/full) among p_REQS requesters.
- Each requester has a valid/ready interface. The arbiter grants bursts of up to p_BURST beats and tags each written word with the source index.
- Sits entirely in the FIFO write clock domain, directly in front of the FIFO write side.

---
 rtl/fifo_write_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing one FIFO write port among p_REQS requesters
module fifo_write_arbiter #(
   parameter int p_WIDTH = 8,
   parameter int p_REQS  = 4,
   parameter int p_BURST = 4,
   localparam int lp_IDX_WIDTH = $clog2(p_REQS)
) (
   input  logic                            iw_clk,
   input  logic                            iw_reset_n,
   input  logic [p_REQS-1:0]               iwv_valid,
   input  logic [p_REQS*p_WIDTH-1:0]       iwv_data,
   output logic [p_REQS-1:0]               owv_ready,
   input  logic                            iw_full,
   output logic                            ow_wrena,
   output logic [lp_IDX_WIDTH+p_WIDTH-1:0] owv_wrdata,
   output logic [p_REQS-1:0]               owv_grant,
   output logic                            ow_busy
);
   localparam int lp_BEAT_WIDTH = $clog2(p_BURST+1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                    r_state, state_nx;
   logic [lp_IDX_WIDTH-1:0]   r_owner, owner_nx, r_last, last_nx;
   logic [lp_BEAT_WIDTH-1:0]  r_beats, beats_nx, beats_inc;
   logic                      owner_valid, beat, release_now;
   logic [p_WIDTH-1:0]        owner_data;

   // First valid index after last, wrapping at p_REQS; last itself is scanned last
   function automatic logic [lp_IDX_WIDTH-1:0] pick(input logic [lp_IDX_WIDTH-1:0] last,
                                                     input logic [p_REQS-1:0] v);
      logic [lp_IDX_WIDTH-1:0] r;
      logic found;
      int j;
      r = '0;
      found = 1'b0;
      for (int k = 1; k <= p_REQS; k++) begin
         j = (int'(last) + k) % p_REQS;
         if (!found && v[j]) begin
            r = lp_IDX_WIDTH'(j);
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // Unregistered datapath: the owner's word goes straight to the FIFO on a handshake
   always_comb begin
      owner_valid = iwv_valid[r_owner];
      owner_data  = iwv_data[r_owner*p_WIDTH +: p_WIDTH];
      ow_busy     = (r_state == GRANT);
      owv_grant   = ow_busy ? (p_REQS'(1) << r_owner) : '0;
      owv_ready   = owv_grant & {p_REQS{~iw_full}};
      beat        = ow_busy & owner_valid & ~iw_full;
      ow_wrena    = beat;
      owv_wrdata  = ow_busy ? {r_owner, owner_data} : '0;
      beats_inc   = r_beats + 1'b1;
      release_now = (beat && beats_inc == lp_BEAT_WIDTH'(p_BURST)) || !owner_valid;
   end

   // Next-state: arbitrate from idle, or hand off directly to the next owner on release
   always_comb begin
      state_nx = r_state;
      owner_nx = r_owner;
      last_nx  = r_last;
      beats_nx = r_beats;
      if (r_state == IDLE) begin
         if (|iwv_valid) begin
            state_nx = GRANT;
            owner_nx = pick(r_last, iwv_valid);
            beats_nx = '0;
         end
      end else if (release_now) begin
         last_nx  = r_owner;
         state_nx = (|iwv_valid) ? GRANT : IDLE;
         owner_nx = (|iwv_valid) ? pick(r_owner, iwv_valid) : r_owner;
         beats_nx = '0;
      end else begin
         beats_nx = beat ? beats_inc : r_beats;
      end
   end

   // State registers; reset aborts any burst immediately
   always_ff @(posedge iw_clk or negedge iw_reset_n) begin
      if (!iw_reset_n) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_last  <= lp_IDX_WIDTH'(p_REQS-1);
         r_beats <= '0;
      end else begin
         r_state <= state_nx;
         r_owner <= owner_nx;
         r_last  <= last_nx;
         r_beats <= beats_nx;
      end
   end
endmodule
